// File: rtl/sync_frame_tx_if.sv
// Handshake and serial-line bundle for sync_frame_tx.
// The bench drives through master; the transmitter uses slave.
interface sync_frame_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  tx_start;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  shift_en;
  logic                  serial_out;
  logic                  busy;
  logic                  tx_done;

  modport master (
    output tx_start, tx_data, shift_en,
    input  serial_out, busy, tx_done
  );

  modport slave (
    input  tx_start, tx_data, shift_en,
    output serial_out, busy, tx_done
  );
endinterface

// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: sync header, MSB-first payload, optional even parity, guard bit.
// Bits advance only on shift_en strobes, so the bit rate is set by whoever generates the strobe.
module sync_frame_tx #(
  parameter int                  DATA_WIDTH   = 8,
  parameter int                  SYNC_LEN     = 4,
  parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = 4'b1101,
  parameter bit                  PARITY_EN    = 1'b1
) (
  input  logic           clk,
  input  logic           n_rst,
  sync_frame_tx_if.slave bus
);

  localparam int CNT_MAX = (SYNC_LEN > DATA_WIDTH) ? SYNC_LEN : DATA_WIDTH;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    PAR,
    GUARD
  } state_t;

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic [SYNC_LEN-1:0]   sync_sr, sync_sr_n;
  logic                  parity, parity_n;
  logic                  serial, serial_n;
  logic                  busy, busy_n;
  logic                  done, done_n;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      sync_sr <= '0;
      parity  <= 1'b0;
      serial  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      shreg   <= shreg_n;
      sync_sr <= sync_sr_n;
      parity  <= parity_n;
      serial  <= serial_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  // Header and payload both leave through their shift register MSB; the counter only marks the last bit.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    shreg_n   = shreg;
    sync_sr_n = sync_sr;
    parity_n  = parity;
    serial_n  = serial;
    busy_n    = busy;
    done_n    = 1'b0;

    case (state)
      IDLE: begin
        serial_n = 1'b0;
        if (bus.tx_start) begin
          shreg_n   = bus.tx_data;
          parity_n  = ^bus.tx_data;
          sync_sr_n = SYNC_PATTERN;
          busy_n    = 1'b1;
          cnt_n     = '0;
          state_n   = SYNC;
        end
      end

      SYNC: begin
        if (bus.shift_en) begin
          serial_n  = sync_sr[SYNC_LEN-1];
          sync_sr_n = sync_sr << 1;
          if (cnt == CNT_W'(SYNC_LEN - 1)) begin
            cnt_n   = '0;
            state_n = DATA;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end

      DATA: begin
        if (bus.shift_en) begin
          serial_n = shreg[DATA_WIDTH-1];
          shreg_n  = shreg << 1;
          if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
            cnt_n   = '0;
            state_n = PARITY_EN ? PAR : GUARD;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end

      PAR: begin
        if (bus.shift_en) begin
          serial_n = parity;
          cnt_n    = '0;
          state_n  = GUARD;
        end
      end

      GUARD: begin
        // First strobe puts the guard 0 on the line; the second one closes the frame.
        if (bus.shift_en) begin
          serial_n = 1'b0;
          if (cnt == '0) begin
            cnt_n = CNT_W'(1);
          end else begin
            cnt_n   = '0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end
      end

      default: begin
        state_n  = IDLE;
        serial_n = 1'b0;
        busy_n   = 1'b0;
        cnt_n    = '0;
      end
    endcase
  end

  assign bus.serial_out = serial;
  assign bus.busy       = busy;
  assign bus.tx_done    = done;

endmodule
